// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Collects results from three producers (EX1, EX2, SLbuffer) into small
//   per-producer FIFOs and broadcasts one entry per cycle on the common data
//   bus, picking among non-empty FIFOs round-robin.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   rdy          global pause; low freezes all state and outputs
//   rst_c        synchronous flush from commit; empties FIFOs, keeps err_o
//   req_valid_i  per-producer result valid (bit0 EX1, bit1 EX2, bit2 SLbuffer)
//   req_id_i     3 x 5-bit ROB ids, producer i at [5i+4:5i]
//   req_data_i   3 x 32-bit results, producer i at [32i+31:32i]
//   req_pc_i     3 x 32-bit branch target PCs, same packing
//   req_cond_i   per-producer branch-taken flag
//   req_full_o   per-producer FIFO full (backpressure)
//   cdb_*_o      registered broadcast: valid, id, data, pc, cond, source
//   err_o        sticky: a valid arrived while its FIFO was full
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rst_c,
    input  logic [2:0]  req_valid_i,
    input  logic [14:0] req_id_i,
    input  logic [95:0] req_data_i,
    input  logic [95:0] req_pc_i,
    input  logic [2:0]  req_cond_i,
    output logic [2:0]  req_full_o,
    output logic        cdb_en_o,
    output logic [4:0]  cdb_id_o,
    output logic [31:0] cdb_data_o,
    output logic [31:0] cdb_pc_o,
    output logic        cdb_cond_o,
    output logic [1:0]  cdb_src_o,
    output logic        err_o
);

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0] CNT_ONE  = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] data;
        logic [31:0] pc;
        logic        cond;
    } entry_t;

    // Producer index after v, wrapping 2 -> 0.
    function automatic logic [1:0] wrap_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    entry_t        mem_q      [3][DEPTH];
    logic [PW-1:0] wr_ptr_q   [3];
    logic [PW-1:0] rd_ptr_q   [3];
    logic [PW:0]   count_q    [3];
    logic [1:0]    last_grant_q;
    entry_t        cdb_q;
    logic          cdb_en_q;
    logic [1:0]    cdb_src_q;
    logic          err_q;

    entry_t        in_entry   [3];
    logic          active;
    logic [2:0]    nonempty;
    logic [2:0]    push;
    logic [2:0]    pop;
    logic [2:0]    overflow;
    logic [1:0]    cand;
    logic          grant_found;
    logic          grant_vld;
    logic [1:0]    grant_idx;
    entry_t        grant_entry;

    // A flush outranks everything; otherwise nothing moves while paused.
    assign active = rdy & ~rst_c;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            in_entry[i].id   = req_id_i[5*i +: 5];
            in_entry[i].data = req_data_i[32*i +: 32];
            in_entry[i].pc   = req_pc_i[32*i +: 32];
            in_entry[i].cond = req_cond_i[i];
            req_full_o[i]    = (count_q[i] == FULL_CNT);
            nonempty[i]      = (count_q[i] != '0);
            // Eligibility uses the pre-edge full flag, so a full FIFO that is
            // being popped this cycle still rejects the new entry.
            push[i]          = req_valid_i[i] & active & ~req_full_o[i];
            overflow[i]      = req_valid_i[i] & active &  req_full_o[i];
        end
    end

    // Round-robin search starting one past the last granted producer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = wrap_inc(last_grant_q);
        for (int k = 0; k < 3; k++) begin
            if (!grant_found && nonempty[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
            cand = wrap_inc(cand);
        end
        grant_vld   = grant_found & active;
        grant_entry = mem_q[grant_idx][rd_ptr_q[grant_idx]];
        for (int i = 0; i < 3; i++) begin
            pop[i] = grant_vld && (grant_idx == 2'(i));
        end
    end

    // NOTE: FIFO storage has no reset; validity is tracked by the reset
    // pointers and counts, so stale contents are never observed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= in_entry[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            last_grant_q <= 2'd2;
            cdb_q        <= '0;
            cdb_en_q     <= 1'b0;
            cdb_src_q    <= 2'd0;
            err_q        <= 1'b0;
        end else if (rst_c) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            last_grant_q <= 2'd2;
            cdb_en_q     <= 1'b0;
        end else if (rdy) begin
            for (int i = 0; i < 3; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_ONE;
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_ONE;
                if (push[i] && !pop[i]) begin
                    count_q[i] <= count_q[i] + CNT_ONE;
                end else if (!push[i] && pop[i]) begin
                    count_q[i] <= count_q[i] - CNT_ONE;
                end
            end
            if (|overflow) err_q <= 1'b1;
            cdb_en_q <= grant_vld;
            if (grant_vld) begin
                cdb_q        <= grant_entry;
                cdb_src_q    <= grant_idx;
                last_grant_q <= grant_idx;
            end
        end
    end

    assign cdb_en_o   = cdb_en_q;
    assign cdb_id_o   = cdb_q.id;
    assign cdb_data_o = cdb_q.data;
    assign cdb_pc_o   = cdb_q.pc;
    assign cdb_cond_o = cdb_q.cond;
    assign cdb_src_o  = cdb_src_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Randomised and directed stimulus for cdb_arbiter. A queue-based reference
//   model predicts every broadcast into a scoreboard; an independent monitor
//   on the falling edge pops and compares whenever the bus shows a new entry,
//   and otherwise checks that the bus holds its last value.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        rst_c = 1'b0;
    logic [2:0]  req_valid_i = '0;
    logic [14:0] req_id_i = '0;
    logic [95:0] req_data_i = '0;
    logic [95:0] req_pc_i = '0;
    logic [2:0]  req_cond_i = '0;
    logic [2:0]  req_full_o;
    logic        cdb_en_o;
    logic [4:0]  cdb_id_o;
    logic [31:0] cdb_data_o;
    logic [31:0] cdb_pc_o;
    logic        cdb_cond_o;
    logic [1:0]  cdb_src_o;
    logic        err_o;

    always #5 clk = ~clk;

    cdb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .rst_c       (rst_c),
        .req_valid_i (req_valid_i),
        .req_id_i    (req_id_i),
        .req_data_i  (req_data_i),
        .req_pc_i    (req_pc_i),
        .req_cond_i  (req_cond_i),
        .req_full_o  (req_full_o),
        .cdb_en_o    (cdb_en_o),
        .cdb_id_o    (cdb_id_o),
        .cdb_data_o  (cdb_data_o),
        .cdb_pc_o    (cdb_pc_o),
        .cdb_cond_o  (cdb_cond_o),
        .cdb_src_o   (cdb_src_o),
        .err_o       (err_o)
    );

    typedef struct {
        logic [4:0]  id;
        logic [31:0] data;
        logic [31:0] pc;
        logic        cond;
        logic [1:0]  src;
    } ent_t;

    // Reference model state.
    ent_t       mq [3][$];
    ent_t       sb [$];
    ent_t       exp_last;
    int         last_g;
    bit         exp_en;
    bit         exp_fresh;
    bit         exp_err;
    bit [2:0]   exp_full;
    bit         chk_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mq[i].delete();
        sb.delete();
        last_g    = 2;
        exp_en    = 1'b0;
        exp_fresh = 1'b0;
        exp_err   = 1'b0;
        exp_full  = '0;
        exp_last  = '{default: '0};
    endtask

    // Predicts the effect of the coming rising edge from the inputs now driven.
    task automatic model_step();
        bit [2:0] full_pre;
        bit       found;
        ent_t     e;
        for (int i = 0; i < 3; i++) full_pre[i] = (mq[i].size() == DEPTH);
        if (rst_c) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            last_g    = 2;
            exp_en    = 1'b0;
            exp_fresh = 1'b1;
        end else if (!rdy) begin
            exp_fresh = 1'b0;
        end else begin
            exp_fresh = 1'b1;
            found     = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (last_g + k) % 3;
                if (!found && mq[c].size() > 0) begin
                    found    = 1'b1;
                    e        = mq[c].pop_front();
                    last_g   = c;
                    sb.push_back(e);
                    exp_last = e;
                end
            end
            exp_en = found;
            for (int i = 0; i < 3; i++) begin
                if (req_valid_i[i]) begin
                    if (full_pre[i]) begin
                        exp_err = 1'b1;
                    end else begin
                        e.id   = req_id_i[5*i +: 5];
                        e.data = req_data_i[32*i +: 32];
                        e.pc   = req_pc_i[32*i +: 32];
                        e.cond = req_cond_i[i];
                        e.src  = 2'(i);
                        mq[i].push_back(e);
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) exp_full[i] = (mq[i].size() == DEPTH);
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    // One cycle of stimulus, applied just after the falling edge.
    task automatic drive(input logic [2:0] v, input logic [14:0] ids,
                         input logic [95:0] data, input logic r, input logic rc);
        @(negedge clk);
        #1;
        req_valid_i = v;
        req_id_i    = ids;
        req_data_i  = data;
        req_pc_i    = rnd96();
        req_cond_i  = 3'($urandom());
        rdy         = r;
        rst_c       = rc;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(3'b000, 15'd0, rnd96(), 1'b1, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_en"},   cdb_en_o,   0);
        check({tag, "_id"},   cdb_id_o,   0);
        check({tag, "_data"}, cdb_data_o, 0);
        check({tag, "_pc"},   cdb_pc_o,   0);
        check({tag, "_cond"}, cdb_cond_o, 0);
        check({tag, "_src"},  cdb_src_o,  0);
        check({tag, "_err"},  err_o,      0);
        check({tag, "_full"}, req_full_o, 0);
    endtask

    task automatic release_rst();
        @(negedge clk);
        #1;
        rst         = 1'b1;
        req_valid_i = '0;
        rdy         = 1'b1;
        rst_c       = 1'b0;
        model_step();
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_zero_outputs("async_rst");
        repeat (2) @(posedge clk);
        release_rst();
    endtask

    // Monitor: decoupled from stimulus, compares the bus against the model.
    ent_t got;
    always @(negedge clk) begin
        if (chk_en && rst) begin
            check("cdb_en",   cdb_en_o,   exp_en);
            check("req_full", req_full_o, exp_full);
            check("err",      err_o,      exp_err);
            if (cdb_en_o && exp_fresh) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: broadcast id=%0d src=%0d, expected none at %0t",
                             cdb_id_o, cdb_src_o, $time);
                end else begin
                    got = sb.pop_front();
                    check("bc_id",   cdb_id_o,   got.id);
                    check("bc_data", cdb_data_o, got.data);
                    check("bc_pc",   cdb_pc_o,   got.pc);
                    check("bc_cond", cdb_cond_o, got.cond);
                    check("bc_src",  cdb_src_o,  got.src);
                end
            end else begin
                check("hold_id",   cdb_id_o,   exp_last.id);
                check("hold_data", cdb_data_o, exp_last.data);
                check("hold_pc",   cdb_pc_o,   exp_last.pc);
                check("hold_cond", cdb_cond_o, exp_last.cond);
                check("hold_src",  cdb_src_o,  exp_last.src);
            end
        end
    end

    initial begin
        model_reset();
        #12;
        check_zero_outputs("por");
        release_rst();
        chk_en = 1'b1;

        // Single request from EX1.
        drive(3'b001, {5'd0, 5'd0, 5'd5}, {64'h0, 32'h12345678}, 1'b1, 1'b0);
        idle(4);

        // Contention, then a lone EX2 entry following without a gap.
        drive(3'b111, {5'd3, 5'd2, 5'd1}, rnd96(), 1'b1, 1'b0);
        idle(1);
        drive(3'b010, {5'd0, 5'd4, 5'd0}, rnd96(), 1'b1, 1'b0);
        idle(5);

        // All busy for 4 cycles fills FIFOs; extra SLbuffer valid overflows.
        for (int i = 0; i < 4; i++) begin
            drive(3'b111, {5'(10 + i), 5'(20 + i), 5'(i)}, rnd96(), 1'b1, 1'b0);
        end
        drive(3'b100, {5'd31, 5'd0, 5'd0}, rnd96(), 1'b1, 1'b0);
        idle(10);

        // Pause with entries pending; requests during the pause are ignored.
        drive(3'b111, {5'd7, 5'd8, 5'd9}, rnd96(), 1'b1, 1'b0);
        drive(3'b000, 15'd0, rnd96(), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(3'b111, {5'd30, 5'd29, 5'd28}, rnd96(), 1'b0, 1'b0);
        idle(6);

        // Flush with entries queued and a same-cycle request, then refill.
        drive(3'b111, {5'd11, 5'd12, 5'd13}, rnd96(), 1'b1, 1'b0);
        drive(3'b111, {5'd14, 5'd15, 5'd16}, rnd96(), 1'b1, 1'b0);
        drive(3'b111, {5'd17, 5'd18, 5'd19}, rnd96(), 1'b1, 1'b1);
        drive(3'b111, {5'd21, 5'd22, 5'd23}, rnd96(), 1'b1, 1'b0);
        idle(5);

        // Flush while paused still empties the FIFOs.
        drive(3'b011, {5'd0, 5'd24, 5'd25}, rnd96(), 1'b1, 1'b0);
        drive(3'b000, 15'd0, rnd96(), 1'b0, 1'b1);
        idle(4);

        // Async reset in mid-burst, then the single-request case again.
        drive(3'b111, {5'd1, 5'd2, 5'd3}, rnd96(), 1'b1, 1'b0);
        drive(3'b111, {5'd4, 5'd5, 5'd6}, rnd96(), 1'b1, 1'b0);
        async_reset();
        drive(3'b001, {5'd0, 5'd0, 5'd5}, {64'h0, 32'h12345678}, 1'b1, 1'b0);
        idle(4);

        // Randomised traffic.
        for (int n = 0; n < 1500; n++) begin
            drive(3'($urandom()), 15'($urandom()), rnd96(),
                  ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 2)  ? 1'b1 : 1'b0);
        end
        idle(12);

        check("sb_drained", 64'(sb.size()), 0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: entries per requester FIFO, power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 rdy  input  1  pause; when low, all state and outputs SHALL freeze, except for rst and rst_c.
REQ-005 rst_c  input  1  synchronous, active-high pipeline flush from commit.
REQ-006 req_valid_i  input  3  per-requester result valid; bit 0 = EX1, bit 1 = EX2, bit 2 = SLbuffer.
REQ-007 req_id_i  input  15  three 5-bit ROB ids, requester i at bits [5i+4:5i].
REQ-008 req_data_i  input  96  three 32-bit results, requester i at bits [32i+31:32i].
REQ-009 req_pc_i  input  96  three 32-bit branch target PCs, same packing.
REQ-010 req_cond_i  input  3  per-requester branch-taken flag.
REQ-011 req_full_o  output  3  per-requester backpressure; FIFO i holds DEPTH entries.
REQ-012 cdb_en_o  output  1  shared CDB broadcast valid.
REQ-013 cdb_id_o  output  5  broadcast ROB id.
REQ-014 cdb_data_o  output  32  broadcast result.
REQ-015 cdb_pc_o  output  32  broadcast PC.
REQ-016 cdb_cond_o  output  1  broadcast cond.
REQ-017 cdb_src_o  output  2  index of the granted requester.
REQ-018 err_o  output  1  sticky overflow flag.

Function
REQ-019 Per-requester FIFO holding {id, data, pc, cond}:
- push when req_valid_i[i] is high, rdy is high, rst_c is low and req_full_o[i] is low;
- req_full_o[i] is combinational from the occupancy count (count equals DEPTH).
REQ-020 Valid with req_full_o[i] high: the entry SHALL be dropped, err_o SHALL set and hold until rst, and FIFO i SHALL be unchanged.
REQ-021 Grant, each cycle with rdy high and rst_c low:
- select exactly one non-empty FIFO, round-robin, searching from (last_grant+1) mod 3 upward with wrap;
- pop its head and update last_grant.
REQ-022 Grant outputs are registered:
- on a grant, cdb_en_o SHALL be 1 in the following cycle, with the popped fields on cdb_id_o/data/pc/cond and the source on cdb_src_o;
- with no grant, cdb_en_o SHALL be 0 and the other outputs SHALL hold their last values.
REQ-023 Latency: an entry pushed at edge E into an otherwise idle arbiter SHALL be granted at E+1 and visible on the CDB during the cycle after E+1; there is no same-cycle bypass.
REQ-024 Simultaneous push and pop on the same FIFO SHALL both occur, and count SHALL be unchanged; push eligibility uses pre-edge req_full_o.
REQ-025 The FIFO SHALL preserve per-requester order; inter-requester order is only the round-robin fairness.
REQ-026 Bandwidth: exactly one broadcast per cycle while any FIFO is non-empty; with all three continuously busy, each requester SHALL be granted once in every 3 cycles.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH.
REQ-028 rst_c high at an edge, regardless of rdy:
- all FIFOs SHALL empty and cdb_en_o SHALL be 0 in the next cycle;
- last_grant SHALL be set to 2;
- same-cycle requests SHALL be discarded;
- err_o SHALL be unaffected.
REQ-029 With rdy low, no push, no pop and no pointer change SHALL occur, and cdb_* SHALL hold, including cdb_en_o.

Reset
REQ-030 rst low SHALL, asynchronously:
- set cdb_en_o=0, cdb_id_o=0, cdb_data_o=0, cdb_pc_o=0, cdb_cond_o=0, cdb_src_o=0 and err_o=0;
- empty all FIFOs, so req_full_o=3'b000;
- set last_grant=2, giving requester 0 first priority.
REQ-031 Reset asserted mid-broadcast or mid-burst SHALL discard all pending entries; after deassertion the block SHALL behave as from power-up.

Verification
REQ-032 Single request: after reset, pulse req_valid_i=3'b001 with id=5, data=0x12345678 -> cdb_en_o=1 two edges later with id=5, data=0x12345678, cdb_src_o=0, for exactly 1 cycle.
REQ-033 Contention: all three valid in the same cycle (ids 1, 2, 3) -> broadcasts ids 1, 2, 3 on consecutive cycles with cdb_src_o 0, 1, 2; a subsequent lone requester-1 entry is granted next with no idle gap.
REQ-034 Full and backpressure: hold requester 2 valid for 4 cycles with DEPTH=2 while 0 and 1 are busy -> req_full_o[2] rises after the 2nd push, and per-source order is preserved; one extra valid while full -> err_o=1, dropped id never appears.
REQ-035 Pause: rdy low for 3 cycles with entries pending -> cdb_* frozen, no pops, and the queue resumes in the identical order once rdy is high.
REQ-036 Flush: rst_c pulse with 4 entries queued plus a same-cycle request -> cdb_en_o=0 next cycle, req_full_o=0, no flushed id ever broadcast, and the next grant goes to requester 0.
REQ-037 Async reset asserted between clock edges during a burst -> outputs zero immediately; after release, REQ-032 passes.
